// File: rtl/matrix_win3x3_1bit.sv
// 3x3 binary window builder fed by a 1-bit line-shift tap interface.
// Optional macro WIN_BORDER_ZERO_EN zeroes the taps of rows above the image.
module matrix_win3x3_1bit #(
    parameter int TAP_LAT = 1,
    parameter int IMG_W   = 640,
    parameter int IMG_H   = 480
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       per_frame_vsync,
    input  logic       per_frame_href,
    input  logic       per_frame_clken,
    input  logic       per_img_bit,
    input  logic       taps0x,
    input  logic       taps1x,
    output logic       matrix_frame_vsync,
    output logic       matrix_frame_href,
    output logic       matrix_frame_clken,
    output logic [8:0] matrix_p,
    output logic       matrix_inside
);

    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    logic [TAP_LAT-1:0] bit_dly_r;
    logic [TAP_LAT-1:0] vsync_dly_r;
    logic [TAP_LAT-1:0] href_dly_r;
    logic [TAP_LAT-1:0] clken_dly_r;
    logic               vsync_prev_r;
    logic               href_prev_r;
    logic [CW-1:0]      col_r;
    logic [RW-1:0]      row_r;
    logic [8:0]         win_r;

    logic               bit_a_s;
    logic               vsync_a_s;
    logic               href_a_s;
    logic               clken_a_s;
    logic               vsync_rise_s;
    logic               href_rise_s;
    logic               href_fall_s;
    logic [CW-1:0]      col_eff_s;
    logic [RW-1:0]      row_eff_s;
    logic               tap0_s;
    logic               tap1_s;
    logic [8:0]         win_base_s;
    logic [8:0]         win_next_s;
    logic [CW-1:0]      col_next_s;
    logic [RW-1:0]      row_next_s;
    logic               inside_s;

    assign bit_a_s      = bit_dly_r[TAP_LAT-1];
    assign vsync_a_s    = vsync_dly_r[TAP_LAT-1];
    assign href_a_s     = href_dly_r[TAP_LAT-1];
    assign clken_a_s    = clken_dly_r[TAP_LAT-1];
    assign vsync_rise_s = vsync_a_s & ~vsync_prev_r;
    assign href_rise_s  = href_a_s & ~href_prev_r;
    assign href_fall_s  = ~href_a_s & href_prev_r;
    // Counter values as seen by the current beat: an edge this cycle restarts them.
    assign col_eff_s    = href_rise_s ? '0 : col_r;
    assign row_eff_s    = vsync_rise_s ? '0 : row_r;
    assign matrix_p     = win_r;

    // Border masking of the row taps
    always_comb begin
        tap0_s = taps0x;
        tap1_s = taps1x;
`ifdef WIN_BORDER_ZERO_EN
        if (row_eff_s == RW'(0)) begin
            tap0_s = 1'b0;
            tap1_s = 1'b0;
        end else if (row_eff_s == RW'(1)) begin
            tap0_s = taps0x;
            tap1_s = 1'b0;
        end else begin
            tap0_s = taps0x;
            tap1_s = taps1x;
        end
`endif
    end

    // Window shift/clear, column/row counting and inside flag
    always_comb begin
        win_base_s = win_r;
        win_next_s = win_r;
        col_next_s = col_eff_s;
        row_next_s = row_eff_s;
        inside_s   = 1'b0;
        if (href_rise_s) begin
            win_base_s = '0;
        end else begin
            win_base_s = win_r;
        end
        if (clken_a_s) begin
            win_next_s = {win_base_s[7:6], tap1_s, win_base_s[4:3], tap0_s,
                          win_base_s[1:0], bit_a_s};
        end else begin
            win_next_s = win_base_s;
        end
        if (clken_a_s && (col_eff_s != CW'(IMG_W - 1))) begin
            col_next_s = col_eff_s + CW'(1);
        end else begin
            col_next_s = col_eff_s;
        end
        if (href_fall_s && (row_eff_s != RW'(IMG_H - 1))) begin
            row_next_s = row_eff_s + RW'(1);
        end else begin
            row_next_s = row_eff_s;
        end
        inside_s = (row_eff_s >= RW'(2)) && (col_eff_s >= CW'(2)) && clken_a_s;
    end

    // Alignment chain, window/counter state and registered outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            bit_dly_r          <= '0;
            vsync_dly_r        <= '0;
            href_dly_r         <= '0;
            clken_dly_r        <= '0;
            vsync_prev_r       <= 1'b0;
            href_prev_r        <= 1'b0;
            col_r              <= '0;
            row_r              <= '0;
            win_r              <= '0;
            matrix_frame_vsync <= 1'b0;
            matrix_frame_href  <= 1'b0;
            matrix_frame_clken <= 1'b0;
            matrix_inside      <= 1'b0;
        end else begin
            bit_dly_r[0]   <= per_img_bit;
            vsync_dly_r[0] <= per_frame_vsync;
            href_dly_r[0]  <= per_frame_href;
            clken_dly_r[0] <= per_frame_clken;
            for (int i = 1; i < TAP_LAT; i++) begin
                bit_dly_r[i]   <= bit_dly_r[i-1];
                vsync_dly_r[i] <= vsync_dly_r[i-1];
                href_dly_r[i]  <= href_dly_r[i-1];
                clken_dly_r[i] <= clken_dly_r[i-1];
            end
            vsync_prev_r       <= vsync_a_s;
            href_prev_r        <= href_a_s;
            col_r              <= col_next_s;
            row_r              <= row_next_s;
            win_r              <= win_next_s;
            matrix_frame_vsync <= vsync_a_s;
            matrix_frame_href  <= href_a_s;
            matrix_frame_clken <= clken_a_s;
            matrix_inside      <= inside_s;
        end
    end

endmodule

// File: tb/tb_matrix_win3x3_1bit.sv
// Directed bench for matrix_win3x3_1bit on a 4x4 image with a one-cycle tap model.
module tb_matrix_win3x3_1bit;

    logic       clock = 1'b0;
    logic       reset;
    logic       per_frame_vsync, per_frame_href, per_frame_clken, per_img_bit;
    logic       taps0x, taps1x;
    logic       matrix_frame_vsync, matrix_frame_href, matrix_frame_clken;
    logic [8:0] matrix_p;
    logic       matrix_inside;
    logic       pend0 = 1'b0;
    logic       pend1 = 1'b0;
    int         total = 0;
    int         bad   = 0;

`ifdef WIN_BORDER_ZERO_EN
    localparam logic [8:0] EXP_RST = 9'h001;
    localparam logic [8:0] EXP_R0  = 9'h007;
    localparam logic [8:0] EXP_R1  = 9'h03F;
    localparam logic [8:0] EXP_G0  = 9'h001;
    localparam logic [8:0] EXP_G1  = 9'h002;
    localparam logic [8:0] EXP_G2  = 9'h005;
    localparam logic [8:0] EXP_G3  = 9'h003;
`else
    localparam logic [8:0] EXP_RST = 9'h049;
    localparam logic [8:0] EXP_R0  = 9'h1FF;
    localparam logic [8:0] EXP_R1  = 9'h1FF;
    localparam logic [8:0] EXP_G0  = 9'h041;
    localparam logic [8:0] EXP_G1  = 9'h0CA;
    localparam logic [8:0] EXP_G2  = 9'h19D;
    localparam logic [8:0] EXP_G3  = 9'h133;
`endif

    matrix_win3x3_1bit #(.TAP_LAT(1), .IMG_W(4), .IMG_H(4)) dut (
        .clock              (clock),
        .reset              (reset),
        .per_frame_vsync    (per_frame_vsync),
        .per_frame_href     (per_frame_href),
        .per_frame_clken    (per_frame_clken),
        .per_img_bit        (per_img_bit),
        .taps0x             (taps0x),
        .taps1x             (taps1x),
        .matrix_frame_vsync (matrix_frame_vsync),
        .matrix_frame_href  (matrix_frame_href),
        .matrix_frame_clken (matrix_frame_clken),
        .matrix_p           (matrix_p),
        .matrix_inside      (matrix_inside)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock; taps given here belong to this beat and appear on the next cycle.
    task automatic step(input logic vs, input logic hr, input logic ck,
                        input logic b, input logic t0, input logic t1);
        per_frame_vsync = vs;
        per_frame_href  = hr;
        per_frame_clken = ck;
        per_img_bit     = b;
        taps0x          = pend0;
        taps1x          = pend1;
        pend0           = t0;
        pend1           = t1;
        @(posedge clock);
        #1;
    endtask

    task automatic frame_start();
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic run_line(input int r, input int n, input logic v,
                            input logic t0, input logic t1);
        for (int c = 0; c <= n; c++) begin
            if (c < n) step(1'b1, 1'b1, 1'b1, v, t0, t1);
            else       step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            if (c >= 1) begin
                chk("inside", 16'(matrix_inside), 16'((r >= 2) && (c - 1 >= 2)));
                chk("line_clken", 16'(matrix_frame_clken), 16'h0001);
            end
        end
    endtask

    initial begin
        logic [8:0] gap_exp [4];
        logic       gb [4];
        logic       g0 [4];
        logic       g1 [4];
        gap_exp = '{EXP_G0, EXP_G1, EXP_G2, EXP_G3};
        gb = '{1'b1, 1'b0, 1'b1, 1'b1};
        g0 = '{1'b0, 1'b1, 1'b1, 1'b0};
        g1 = '{1'b1, 1'b1, 1'b0, 1'b0};

        // Reset state, then reset mid-line on an all-ones image
        reset = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("rst_p", 16'(matrix_p), 16'h0000);
        chk("rst_sync", 16'({matrix_frame_vsync, matrix_frame_href, matrix_frame_clken, matrix_inside}), 16'h0000);
        reset = 1'b0;
        frame_start();
        for (int k = 0; k < 4; k++) step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        reset = 1'b1;
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        chk("midrst_p", 16'(matrix_p), 16'h0000);
        chk("midrst_sync", 16'({matrix_frame_vsync, matrix_frame_href, matrix_frame_clken, matrix_inside}), 16'h0000);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        chk("midrst_p3", 16'(matrix_p), 16'h0000);
        reset = 1'b0;
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("post_rst_idle", 16'({matrix_frame_href, matrix_frame_clken}), 16'h0000);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        chk("post_rst_clken1", 16'(matrix_frame_clken), 16'h0000);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("post_rst_clken2", 16'(matrix_frame_clken), 16'h0001);
        chk("post_rst_p", 16'(matrix_p), 16'(EXP_RST));
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Latency: single line, bits 1,0,1
        frame_start();
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("lat_first", 16'(matrix_frame_clken), 16'h0000);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("lat_row3_early", 16'(matrix_p[2:0]), 16'h0002);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("lat_clken", 16'(matrix_frame_clken), 16'h0001);
        chk("lat_row3", 16'(matrix_p[2:0]), 16'h0005);
        chk("lat_inside", 16'(matrix_inside), 16'h0000);

        // Row stacking on a 4x4 frame; last line overruns the width
        frame_start();
        for (int r = 0; r < 4; r++) begin
            run_line(r, (r == 3) ? 6 : 4, logic'((r % 2) == 0),
                     (r >= 1) ? logic'(((r - 1) % 2) == 0) : 1'b0,
                     (r >= 2) ? logic'(((r - 2) % 2) == 0) : 1'b0);
            if (r == 2) chk("stack_p", 16'(matrix_p), 16'h01C7);
        end
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("col_sat", 16'(dut.col_r), 16'h0003);
        chk("row_sat", 16'(dut.row_r), 16'h0003);

        // Border rows with stale all-ones taps
        frame_start();
        run_line(0, 4, 1'b1, 1'b1, 1'b1);
        chk("border_r0", 16'(matrix_p), 16'(EXP_R0));
        run_line(1, 4, 1'b1, 1'b1, 1'b1);
        chk("border_r1", 16'(matrix_p), 16'(EXP_R1));
        run_line(2, 4, 1'b1, 1'b1, 1'b1);
        chk("border_r2", 16'(matrix_p), 16'h01FF);

        // Gapped clken: two idle cycles after every beat
        frame_start();
        for (int k = 0; k < 4; k++) begin
            step(1'b1, 1'b1, 1'b1, gb[k], g0[k], g1[k]);
            step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            chk("gap_win_a", 16'(matrix_p), 16'(gap_exp[k]));
            step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            chk("gap_win_b", 16'(matrix_p), 16'(gap_exp[k]));
            chk("gap_col", 16'(dut.col_r), 16'((k + 1 > 3) ? 3 : k + 1));
        end

        // Line restart: window clears on the new href before any beat
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("restart_hold", 16'(matrix_p), 16'(EXP_G3));
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("restart_p", 16'(matrix_p), 16'h0000);
        chk("restart_col", 16'(dut.col_r), 16'h0000);
        chk("restart_row", 16'(dut.row_r), 16'h0001);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("restart_col1", 16'(dut.col_r), 16'h0001);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
